// File: rtl/tia_horizontal_pkg.sv
// Shared definitions for the TIA horizontal counter blocks.
// The decode constants are 6-bit LFSR states written a..f, MSB first.
// The match-vector indices give the bit layout {shb,SHS,RHS,RCB,RHB,LRHB,CNT}.
// tia_horizontal_lfsr uses this package too.
package tia_horizontal_pkg;

    localparam logic [5:0] PAT_SHS  = 6'b111100;  // set hsync
    localparam logic [5:0] PAT_RHS  = 6'b110111;  // reset hsync, set colour burst
    localparam logic [5:0] PAT_RCB  = 6'b001111;  // reset colour burst
    localparam logic [5:0] PAT_RHB  = 6'b011101;  // reset hblank (normal)
    localparam logic [5:0] PAT_LRHB = 6'b010111;  // reset hblank (late, after HMOVE)
    localparam logic [5:0] PAT_CNT  = 6'b101100;  // centre pulse

    localparam int MATCH_W = 7;
    localparam int M_CNT   = 0;
    localparam int M_LRHB  = 1;
    localparam int M_RHB   = 2;
    localparam int M_RCB   = 3;
    localparam int M_RHS   = 4;
    localparam int M_SHS   = 5;
    localparam int M_SHB   = 6;

endpackage

// File: rtl/tia_phase_srff.sv
// Phase-enabled set/reset flop.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset; loads RST_VAL
//   en  - phase enable; set/clr act only when en=1
//   set - set request (wins over clr)
//   clr - clear request
//   q   - registered output
module tia_phase_srff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic set,
    input  logic clr,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            if (set) begin
                q <= 1'b1;
            end else if (clr) begin
                q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tia_horizontal_decode.sv
// Horizontal event decoder for the TIA line timing.
// On hphi1 it samples the LFSR state and the shb strobe into a one-hot match
// vector. On the following hphi2 it applies that vector to the line-timing
// flops, then clears the vector so each decode acts once.
// Ports:
//   clk               - system clock, rising edge
//   rsyn              - synchronous active-high reset / RSYNC strobe
//   hphi1, hphi2      - biphase enables
//   a..f              - LFSR state bits
//   shb               - start-HBLANK strobe
//   hmove             - HMOVE strobe; arms late HBLANK reset
//   hsync, hblank, cb - line-timing outputs
//   cnt               - centre pulse, one hphi2 period wide
//   sec               - HMOVE latch state
//   phase_err         - sticky; set when both phases are high together
module tia_horizontal_decode
    import tia_horizontal_pkg::*;
#(
    parameter bit LATE_HBLANK_EN  = 1'b1,
    parameter bit HBLANK_ON_RESET = 1'b1
) (
    input  logic clk,
    input  logic rsyn,
    input  logic hphi1,
    input  logic hphi2,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    input  logic f,
    input  logic shb,
    input  logic hmove,
    output logic hsync,
    output logic hblank,
    output logic cb,
    output logic cnt,
    output logic sec,
    output logic phase_err
);

    logic               ph1_act;
    logic               ph2_act;
    logic [5:0]         lfsr;
    logic [MATCH_W-1:0] dec;
    logic [MATCH_W-1:0] mv;
    logic               hb_clr;

    // A stage acts only when its phase is high alone. Overlap is an error.
    assign ph1_act = hphi1 & ~hphi2;
    assign ph2_act = hphi2 & ~hphi1;
    assign lfsr    = {a, b, c, d, e, f};

    always_comb begin
        dec         = '0;
        dec[M_SHB]  = shb;
        dec[M_SHS]  = (lfsr == PAT_SHS);
        dec[M_RHS]  = (lfsr == PAT_RHS);
        dec[M_RCB]  = (lfsr == PAT_RCB);
        dec[M_RHB]  = (lfsr == PAT_RHB);
        dec[M_LRHB] = (lfsr == PAT_LRHB);
        dec[M_CNT]  = (lfsr == PAT_CNT);
    end

    // Each hphi2 consumes the match vector. A later hphi2 with no new hphi1
    // therefore does nothing.
    always_ff @(posedge clk) begin
        if (rsyn) begin
            mv        <= '0;
            cnt       <= 1'b0;
            phase_err <= 1'b0;
        end else begin
            if (ph1_act) begin
                mv <= dec;
            end else if (ph2_act) begin
                mv  <= '0;
                cnt <= mv[M_CNT];
            end
            if (hphi1 && hphi2) begin
                phase_err <= 1'b1;
            end
        end
    end

    // After an HMOVE, sec=1. RHB is then ignored and LRHB ends the blank.
    assign hb_clr = (mv[M_RHB] & ~sec) | (mv[M_LRHB] & sec);

    tia_phase_srff #(.RST_VAL(1'b0)) u_hsync (
        .clk (clk), .rst (rsyn), .en (ph2_act),
        .set (mv[M_SHS]), .clr (mv[M_RHS]), .q (hsync)
    );

    tia_phase_srff #(.RST_VAL(HBLANK_ON_RESET)) u_hblank (
        .clk (clk), .rst (rsyn), .en (ph2_act),
        .set (mv[M_SHB]), .clr (hb_clr), .q (hblank)
    );

    tia_phase_srff #(.RST_VAL(1'b0)) u_cb (
        .clk (clk), .rst (rsyn), .en (ph2_act),
        .set (mv[M_RHS]), .clr (mv[M_RCB]), .q (cb)
    );

    // hmove acts on any edge. It beats the LRHB clear on the same edge.
    tia_phase_srff #(.RST_VAL(1'b0)) u_sec (
        .clk (clk), .rst (rsyn), .en (1'b1),
        .set (hmove & LATE_HBLANK_EN), .clr (ph2_act & mv[M_LRHB]), .q (sec)
    );

endmodule

// File: tb/tb_tia_horizontal_decode.sv
module tb_tia_horizontal_decode;
    import tia_horizontal_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rsyn = 1'b1, hphi1 = 1'b0, hphi2 = 1'b0;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0, f = 1'b0;
    logic shb = 1'b0, hmove = 1'b0;
    logic hsync, hblank, cb, cnt, sec, phase_err;

    tia_horizontal_decode dut (
        .clk (clk), .rsyn (rsyn), .hphi1 (hphi1), .hphi2 (hphi2),
        .a (a), .b (b), .c (c), .d (d), .e (e), .f (f),
        .shb (shb), .hmove (hmove),
        .hsync (hsync), .hblank (hblank), .cb (cb), .cnt (cnt),
        .sec (sec), .phase_err (phase_err)
    );

    // scoreboard
    logic [5:0] exp_q[$];
    string      tag_q[$];
    int         checks = 0;
    int         errors = 0;
    string      cur_tag = "reset";

    // reference model: line-timing state plus the pattern captured at hphi1
    bit         m_hs, m_hb, m_cb, m_cn, m_sc, m_pe;
    bit         lat_valid;
    logic [5:0] lat_pat;
    bit         lat_shb;

    function automatic void model_step(input bit r, input bit p1, input bit p2,
                                       input logic [5:0] pat, input bit s, input bit hm);
        bit hb_old_sc;
        if (r) begin
            m_hs = 0; m_hb = 1; m_cb = 0; m_cn = 0; m_sc = 0; m_pe = 0;
            lat_valid = 0;
            return;
        end
        hb_old_sc = m_sc;
        if (p1 && p2) begin
            m_pe = 1;
        end else if (p1) begin
            lat_valid = 1; lat_pat = pat; lat_shb = s;
        end else if (p2) begin
            if (lat_valid) begin
                if (lat_pat == PAT_SHS) m_hs = 1;
                if (lat_pat == PAT_RHS) begin m_hs = 0; m_cb = 1; end
                if (lat_pat == PAT_RCB) m_cb = 0;
                if (lat_pat == PAT_RHB && !hb_old_sc) m_hb = 0;
                if (lat_pat == PAT_LRHB && hb_old_sc) m_hb = 0;
                if (lat_shb) m_hb = 1;
                m_cn = (lat_pat == PAT_CNT);
                if (lat_pat == PAT_LRHB) m_sc = 0;
            end else begin
                m_cn = 0;
            end
            lat_valid = 0;
        end
        if (hm) m_sc = 1;
    endfunction

    // driver: inputs change on negedge, expectation pushed after the posedge
    task automatic drive(input bit r, input bit p1, input bit p2,
                         input logic [5:0] pat, input bit s, input bit hm);
        @(negedge clk);
        rsyn = r; hphi1 = p1; hphi2 = p2; {a, b, c, d, e, f} = pat;
        shb = s; hmove = hm;
        @(posedge clk);
        model_step(r, p1, p2, pat, s, hm);
        exp_q.push_back({m_hs, m_hb, m_cb, m_cn, m_sc, m_pe});
        tag_q.push_back(cur_tag);
    endtask

    // one hphi1/hphi2 pair with the pattern held throughout
    task automatic pair(input logic [5:0] pat, input bit s);
        drive(0, 1, 0, pat, s, 0);
        drive(0, 0, 0, pat, s, 0);
        drive(0, 0, 1, pat, s, 0);
        drive(0, 0, 0, pat, s, 0);
    endtask

    task automatic chk(input string nm, input logic act, input logic exp_v, input string tg);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s/%s: got %b expected %b at %0t", tg, nm, act, exp_v, $time);
        end
    endtask

    // monitor: outputs are compared on the edge opposite the active one
    initial begin
        logic [5:0] ev;
        string      tg;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                tg = tag_q.pop_front();
                chk("hsync",     hsync,     ev[5], tg);
                chk("hblank",    hblank,    ev[4], tg);
                chk("cb",        cb,        ev[3], tg);
                chk("cnt",       cnt,       ev[2], tg);
                chk("sec",       sec,       ev[1], tg);
                chk("phase_err", phase_err, ev[0], tg);
            end
        end
    end

    logic [5:0] pats[7];

    initial begin
        pats[0] = PAT_SHS; pats[1] = PAT_RHS; pats[2] = PAT_RCB; pats[3] = PAT_RHB;
        pats[4] = PAT_LRHB; pats[5] = PAT_CNT; pats[6] = 6'b000000;

        // 1: reset, then idle phases
        cur_tag = "reset";
        drive(1, 0, 0, 6'h00, 0, 0);
        drive(1, 0, 0, 6'h00, 0, 0);
        drive(0, 0, 0, 6'h00, 0, 0);
        drive(0, 0, 0, 6'h00, 0, 0);

        // 2: pattern walk
        cur_tag = "shs";  pair(PAT_SHS, 0);
        cur_tag = "rhs";  pair(PAT_RHS, 0);
        cur_tag = "rcb";  pair(PAT_RCB, 0);
        cur_tag = "rhb";  pair(PAT_RHB, 0);
        cur_tag = "shb";  pair(6'h00, 1);

        // 3: hmove selects late HBLANK reset
        cur_tag = "hmove";     drive(0, 0, 0, 6'h00, 0, 1);
        cur_tag = "rhb_late";  pair(PAT_RHB, 0);
        cur_tag = "lrhb";      pair(PAT_LRHB, 0);

        // shb coinciding with a pattern still leaves hblank set
        cur_tag = "shb_rhb";   pair(PAT_RHB, 1);

        // hmove on the LRHB apply edge: set wins
        cur_tag = "hm_lrhb";
        drive(0, 0, 0, 6'h00, 0, 1);
        drive(0, 1, 0, PAT_LRHB, 0, 0);
        drive(0, 0, 1, PAT_LRHB, 0, 1);
        drive(0, 0, 0, 6'h00, 0, 0);

        // 4: centre pulse lasts one hphi2 period
        cur_tag = "cnt";       pair(PAT_CNT, 0);
        cur_tag = "cnt_off";   pair(6'b000000, 0);
        cur_tag = "cnt_none";  pair(6'b000000, 0);

        // a second hphi2 without a new hphi1 does nothing
        cur_tag = "no_reuse";
        pair(PAT_SHS, 0);
        drive(0, 0, 1, PAT_RHS, 0, 0);
        drive(0, 0, 0, PAT_RHS, 0, 0);

        // 5: rsyn on the edge that would apply RHS
        cur_tag = "rsyn_mid";
        drive(0, 1, 0, PAT_RHS, 0, 0);
        drive(0, 0, 0, PAT_RHS, 0, 0);
        drive(1, 0, 1, PAT_RHS, 0, 1);
        drive(0, 0, 0, 6'h00, 0, 0);
        cur_tag = "rcb_after"; pair(PAT_RCB, 0);

        // a capture taken during rsyn is not applied afterwards
        cur_tag = "rsyn_p1";
        drive(1, 1, 0, PAT_SHS, 0, 0);
        drive(0, 0, 1, PAT_SHS, 0, 0);
        drive(0, 0, 0, 6'h00, 0, 0);

        // 6: overlapping phases
        cur_tag = "overlap";
        drive(0, 1, 1, PAT_SHS, 0, 0);
        drive(0, 0, 0, 6'h00, 0, 0);
        pair(PAT_CNT, 0);
        drive(1, 0, 0, 6'h00, 0, 0);
        drive(0, 0, 0, 6'h00, 0, 0);

        // randomized line activity
        cur_tag = "random";
        for (int i = 0; i < 400; i++) begin
            int ph;
            bit p1, p2;
            logic [5:0] pat;
            ph = $urandom_range(0, 99);
            p1 = (ph < 35) || (ph >= 97);
            p2 = (ph >= 35 && ph < 70) || (ph >= 97);
            if ($urandom_range(0, 3) == 0) pat = 6'($urandom_range(0, 63));
            else                           pat = pats[$urandom_range(0, 6)];
            drive(($urandom_range(0, 99) < 2), p1, p2, pat,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        // drain the scoreboard
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
